// File: rtl/op_alu_pkg.sv
// Shared definitions for the sequential operator unit: opcode numbering,
// FSM state encoding and default datapath sizes.
package op_alu_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_OPW   = 4;

  localparam int OP_ADD  = 0;
  localparam int OP_SHR  = 1;
  localparam int OP_GT   = 2;
  localparam int OP_EQ   = 3;
  localparam int OP_AND  = 4;
  localparam int OP_ORR  = 5;
  localparam int OP_LOR  = 6;
  localparam int OP_CAT  = 7;
  localparam int OP_SEL  = 8;
  localparam int OP_LAST = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of a shift counter able to hold the saturated amount (0..w).
  function automatic int shift_count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/op_alu_shifter.sv
// Iterative logical right shifter: loads a value and amount, then shifts one
// bit per cycle; done flags the cycle whose shifted output is the final one.
module op_alu_shifter
  import op_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = shift_count_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic [CW-1:0]    amount,
  output logic [WIDTH-1:0] shifted,
  output logic             done
);

  logic [WIDTH-1:0] value_reg, value_next;
  logic [CW-1:0]    count_reg, count_next;

  always_comb begin
    value_next = value_reg;
    count_next = count_reg;
    if (load) begin
      value_next = value;
      count_next = amount;
    end else if (count_reg != '0) begin
      value_next = value_reg >> 1;
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= '0;
      count_reg <= '0;
    end else begin
      value_reg <= value_next;
      count_reg <= count_next;
    end
  end

  // Exposes the value after the pending shift so the caller can capture the
  // final result on the same edge the last shift happens.
  assign shifted = value_reg >> 1;
  assign done    = (count_reg == CW'(1));

endmodule

// File: rtl/op_alu_seq.sv
// Handshaked operator unit: single-cycle ops computed at accept, SHR sequenced
// through op_alu_shifter. Optional port `illegal` under OP_ALU_SEQ_ILLEGAL_FLAG_EN.
module op_alu_seq
  import op_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OPW   = DEFAULT_OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef OP_ALU_SEQ_ILLEGAL_FLAG_EN
  ,
  output logic             illegal
`endif
);

  localparam int CW  = shift_count_width(WIDTH);
  localparam int WP1 = WIDTH + 1;

  localparam logic [OPW-1:0] C_ADD  = OPW'(OP_ADD);
  localparam logic [OPW-1:0] C_SHR  = OPW'(OP_SHR);
  localparam logic [OPW-1:0] C_GT   = OPW'(OP_GT);
  localparam logic [OPW-1:0] C_EQ   = OPW'(OP_EQ);
  localparam logic [OPW-1:0] C_AND  = OPW'(OP_AND);
  localparam logic [OPW-1:0] C_ORR  = OPW'(OP_ORR);
  localparam logic [OPW-1:0] C_LOR  = OPW'(OP_LOR);
  localparam logic [OPW-1:0] C_CAT  = OPW'(OP_CAT);
  localparam logic [OPW-1:0] C_SEL  = OPW'(OP_SEL);
  localparam logic [WIDTH:0] W_SAT  = WP1'(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] and_bits;
  logic [CW-1:0]    shr_amount;
  logic             accept;
  logic             sh_load;
  logic             sh_done;
  logic [WIDTH-1:0] sh_shifted;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_and
      assign and_bits[gi] = b[gi] & c[gi];
    end
  endgenerate

  // Single-cycle operators, evaluated straight from the inputs so the
  // result can be registered on the accepting edge.
  always_comb begin
    alu_result = '0;
    case (op)
      C_ADD:   alu_result = b + c;
      C_SHR:   alu_result = b;  // only used when the shift amount is zero
      C_GT:    alu_result = WIDTH'(a > b);
      C_EQ:    alu_result = WIDTH'(a == d);
      C_AND:   alu_result = and_bits;
      C_ORR:   alu_result = WIDTH'(|b);
      C_LOR:   alu_result = WIDTH'((a > b) || (a > d));
      C_CAT:   alu_result = {c[WIDTH/2-1:0], d[WIDTH-1:WIDTH/2]};
      C_SEL:   alu_result = (a > b) ? a : b;
      default: alu_result = '0;
    endcase
  end

  // Shifting by WIDTH or more always clears the value, so cap the cycle count.
  assign shr_amount = ({1'b0, c} >= W_SAT) ? CW'(WIDTH) : CW'(c);
  assign accept     = in_valid && (state_reg == IDLE);

  op_alu_shifter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .value   (b),
    .amount  (shr_amount),
    .shifted (sh_shifted),
    .done    (sh_done)
  );

`ifdef OP_ALU_SEQ_ILLEGAL_FLAG_EN
  logic illegal_reg, illegal_next;
  logic op_illegal;

  assign op_illegal = (op > OPW'(OP_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    illegal_next = illegal_reg;
    if (accept) begin
      illegal_next = op_illegal;
    end
  end

  assign illegal = illegal_reg;
`endif

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    sh_load     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if ((op == C_SHR) && (c != '0)) begin
            sh_load    = 1'b1;
            state_next = SHIFT;
          end else begin
            result_next = alu_result;
            state_next  = DONE;
          end
        end
      end
      SHIFT: begin
        if (sh_done) begin
          result_next = sh_shifted;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign result    = result_reg;

endmodule

// File: tb/tb_op_alu_seq.sv
// Scoreboard bench for op_alu_seq: expected results are queued at drive time
// and compared when the unit presents them.
module tb_op_alu_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic [3:0] d;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       busy;
`ifdef OP_ALU_SEQ_ILLEGAL_FLAG_EN
  logic       illegal;
`endif

  op_alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
`ifdef OP_ALU_SEQ_ILLEGAL_FLAG_EN
    ,
    .illegal   (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [3:0] res;
    logic       ill;
  } sb_t;

  sb_t sb_q[$];
  int  tests;
  int  failed;
  int  results_seen;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model(input logic [3:0] o, input logic [3:0] x,
                                       input logic [3:0] y, input logic [3:0] z,
                                       input logic [3:0] w);
    logic [3:0] r;
    r = 4'd0;
    case (o)
      4'd0: r = y + z;
      4'd1: r = y >> z;
      4'd2: r = (x > y) ? 4'd1 : 4'd0;
      4'd3: r = (x == w) ? 4'd1 : 4'd0;
      4'd4: r = y & z;
      4'd5: r = (y != 4'd0) ? 4'd1 : 4'd0;
      4'd6: r = ((x > y) || (x > w)) ? 4'd1 : 4'd0;
      4'd7: r = {z[1:0], w[3:2]};
      4'd8: r = (x > y) ? x : y;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [3:0] o, input logic [3:0] z);
    if (o == 4'd1 && z != 4'd0) return 1 + ((z > 4'd4) ? 4 : int'(z));
    return 1;
  endfunction

  // Output monitor: one comparison set per consumed result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check_val("sb_pending", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        sb_t e;
        e = sb_q.pop_front();
        check_val("result", result, e.res);
`ifdef OP_ALU_SEQ_ILLEGAL_FLAG_EN
        check_val("illegal", illegal, e.ill);
`endif
        results_seen++;
        $display("[TB] txn op=%0d result=%0h expected=%0h", e.op, result, e.res);
      end
    end
  end

  task automatic run_op(input logic [3:0] o, input logic [3:0] ai, input logic [3:0] bi,
                        input logic [3:0] ci, input logic [3:0] di,
                        input logic [3:0] er, input int el);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_val("in_ready_wait", in_ready, 1);
    @(posedge clk); #1;
    op = o; a = ai; b = bi; c = ci; d = di;
    in_valid = 1'b1;
    sb_q.push_back(sb_t'{o, er, (o > 4'd8)});
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = 4'($urandom); b = 4'($urandom);
    c = 4'($urandom);  d = 4'($urandom);
    k = 1;
    @(negedge clk);
    check_val("busy", busy, 1);
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_val("latency", k, el);
    if (out_ready) begin
      @(negedge clk);
      check_val("in_ready_ret", in_ready, 1);
      check_val("out_valid_clr", out_valid, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] ro, ra, rb, rc, rd;
    tests = 0; failed = 0; results_seen = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; a = 4'd0; b = 4'd0; c = 4'd0; d = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_result", result, 0);
    check_val("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Arithmetic wrap and shifts.
    run_op(4'd0, 4'd0, 4'd9, 4'd8, 4'd0, 4'd1, 1);
    run_op(4'd1, 4'd0, 4'b1100, 4'd2, 4'd0, 4'b0011, 3);
    run_op(4'd1, 4'd0, 4'b1100, 4'd7, 4'd0, 4'd0, 5);
    run_op(4'd1, 4'd0, 4'b1100, 4'd0, 4'd0, 4'b1100, 1);
    run_op(4'd1, 4'd0, 4'b1111, 4'd4, 4'd0, 4'd0, 5);
    run_op(4'd1, 4'd0, 4'b1001, 4'd1, 4'd0, 4'b0100, 2);
    run_op(4'd1, 4'd0, 4'b1011, 4'd3, 4'd0, 4'b0001, 4);

    // Single-cycle ops on a=5, b=3, c=0110, d=1010.
    run_op(4'd2, 4'd5, 4'd3, 4'b0110, 4'b1010, 4'd1, 1);
    run_op(4'd3, 4'd5, 4'd3, 4'b0110, 4'b1010, 4'd0, 1);
    run_op(4'd4, 4'd5, 4'd3, 4'b0110, 4'b1010, 4'd2, 1);
    run_op(4'd5, 4'd5, 4'd3, 4'b0110, 4'b1010, 4'd1, 1);
    run_op(4'd6, 4'd5, 4'd3, 4'b0110, 4'b1010, 4'd1, 1);
    run_op(4'd7, 4'd5, 4'd3, 4'b0110, 4'b1010, 4'b1010, 1);
    run_op(4'd8, 4'd5, 4'd3, 4'b0110, 4'b1010, 4'd5, 1);

    // Opposite outcomes of the relational/reduction ops.
    run_op(4'd2, 4'd3, 4'd5, 4'd0, 4'd0, 4'd0, 1);
    run_op(4'd3, 4'd7, 4'd0, 4'd0, 4'd7, 4'd1, 1);
    run_op(4'd6, 4'd2, 4'd3, 4'd0, 4'd1, 4'd1, 1);
    run_op(4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1);
    run_op(4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1);
    run_op(4'd8, 4'd2, 4'd9, 4'd0, 4'd0, 4'd9, 1);

    // Illegal opcodes and a legal op afterwards to clear the flag.
    run_op(4'd12, 4'd5, 4'd3, 4'd6, 4'd10, 4'd0, 1);
    run_op(4'd9, 4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 1);
    run_op(4'd15, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 1);
    run_op(4'd0, 4'd0, 4'd7, 4'd7, 4'd0, 4'd14, 1);

    // Back-pressure: result held, inputs ignored while DONE.
    out_ready = 1'b0;
    run_op(4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd3, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op = 4'd0; b = 4'hF; c = 4'hF;
      @(negedge clk);
      check_val("bp_result", result, 3);
      check_val("bp_out_valid", out_valid, 1);
      check_val("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = results_seen;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("bp_consumed", results_seen, n + 1);
    check_val("bp_out_valid_clr", out_valid, 0);
    check_val("bp_in_ready_ret", in_ready, 1);

    // Reset while shifting aborts the transaction.
    @(posedge clk); #1;
    op = 4'd1; b = 4'hF; c = 4'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_val("abort_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("abort_in_ready", in_ready, 1);
    check_val("abort_out_valid", out_valid, 0);
    check_val("abort_result", result, 0);
    check_val("abort_busy_clr", busy, 0);
    n = results_seen;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("abort_no_output", out_valid, 0);
    end
    check_val("abort_no_result", results_seen, n);

    // Random traffic against the model.
    for (int i = 0; i < 30; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom); rd = 4'($urandom);
      run_op(ro, ra, rb, rc, rd, model(ro, ra, rb, rc, rd), lat_of(ro, rc));
    end

    repeat (3) @(negedge clk);
    check_val("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/op_alu_seq.md
Name: op_alu_seq

Overview:
- Sequential, handshake-driven operator unit. It computes one operator per transaction over latched 4-bit operands.
- Opcode selects from the team's standard operator set: arithmetic, shift, relational, equality, bitwise, reduction, logical, concatenation and conditional.
- Sits between an operand producer and a result consumer. Both sides use valid/ready handshakes.
- Variable right shift runs iteratively, one bit per cycle. All other ops complete in one cycle.

Parameters:
- WIDTH, 4, operand/result width in bits. Must be even and at least 2.
- OPW, 4, opcode width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset.
- in_valid  input  1  producer presents op and operands.
- in_ready  output  1  unit can accept a transaction.
- op  input  OPW  opcode.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  WIDTH  operand C.
- d  input  WIDTH  operand D.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, internal operand/shift counter registers=0.
- Reset mid-operation aborts the transaction. No result is emitted.
- Opcodes (all zero-extended to WIDTH):
  - 0 ADD = b+c mod 2^WIDTH
  - 1 SHR = b>>c, logical
  - 2 GT = (a>b)
  - 3 EQ = (a==d)
  - 4 AND = b&c
  - 5 ORR = |b
  - 6 LOR = (a>b)||(a>d)
  - 7 CAT = {c[WIDTH/2-1:0], d[WIDTH-1:WIDTH/2]}
  - 8 SEL = (a>b)?a:b
  - 9..15 illegal: result=0
- All comparisons are unsigned.
- Handshake:
  - Accept occurs when in_valid && in_ready. in_ready = (state==IDLE).
  - op/a/b/c/d are latched on accept. Later input changes are ignored.
  - There is no combinational path from inputs to outputs.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE to DONE: on accept of any op other than SHR. Result is registered on the same edge.
  - IDLE to SHIFT: on accept of SHR with c≠0. Shift register loads b; count loads min(c, WIDTH).
  - IDLE to DONE: on accept of SHR with c=0. Result = b.
  - SHIFT: each cycle shifts right by 1 and decrements count. When count reaches 1, the final shift is written to result and state moves to DONE.
  - DONE: out_valid=1 and result is held stable. On out_ready, state moves to IDLE and out_valid clears on the next edge.
- Latency, with accept at edge N:
  - Non-SHR ops and SHR with c=0: out_valid high after edge N+1.
  - SHR: out_valid high after edge N+1+min(c,WIDTH).
  - c≥WIDTH saturates to WIDTH cycles and gives result 0.
- Back-pressure: out_ready low holds DONE indefinitely, with result unchanged and in_ready=0.
- No overlap: a new transaction is accepted only in IDLE, so throughput is at most one per 2 cycles.
- Simultaneous rst with in_valid or out_ready: rst wins.

Optional Feature:
- Macro: OP_ALU_SEQ_ILLEGAL_FLAG_EN.
- With the macro defined: adds output port `illegal` (1 bit).
  - Registered alongside result; valid while out_valid=1.
  - Set to 1 for opcodes 9..15, otherwise 0. Reset value 0.
- Without the macro: port absent. Illegal opcodes silently return 0 with normal one-cycle latency.

Decomposition:
- Shared package op_alu_pkg holds:
  - opcode localparams OP_ADD..OP_SEL, plus OP_LAST=8
  - FSM state typedef (IDLE/SHIFT/DONE)
  - default WIDTH constant
- One natural sub-module: op_alu_shifter, the iterative right-shift datapath.
  - Inputs: load, value, amount.
  - Outputs: shifted value, done.
  - The top-level FSM sequences it.
- All other ops stay inline in a single-cycle compute block.

Test Plan:
- Reset then ADD, a=0, b=9, c=8, out_ready=1 → out_valid after 1 cycle, result=1 (wrap); in_ready returns high the following cycle.
- SHR b=4'b1100, c=2 → busy for 2 SHIFT cycles, then result=4'b0011. SHR c=7 → 4 SHIFT cycles, result=0. SHR c=0 → result=b in 1 cycle.
- Ops 2–8 with a=5, b=3, c=4'b0110, d=4'b1010 → GT=1, EQ=0, AND=2, ORR=1, LOR=1, CAT=4'b1010, SEL=5.
- out_ready held low 5 cycles in DONE → result stable, out_valid=1, in_ready=0, and in_valid pulses are ignored. Release → one result consumed.
- rst asserted during the SHIFT phase of SHR c=4 → next cycle IDLE, out_valid=0, result=0; no result emitted later.
- op=12 → result=0. With OP_ALU_SEQ_ILLEGAL_FLAG_EN defined: illegal=1, and illegal=0 for op=0.
